multicycle_ctrl: RTL

Control FSM for the multicycle datapath. It takes the opcode, funct and ALU zero flag from the decoder and datapath each cycle. It drives instruction and data memory requests, PC/IR/register-file enables and datapath mux selects, executing one instruction at a time through FETCH/DECODE/EXEC/MEM/WB. It sits between the decoder and the datapath muxes, and is the only source of `halt`.

---
 rtl/cpu_types_pkg.sv | 58 +++++
 rtl/alu_ctrl.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction fields, ALU ops and multicycle control selects.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OpRtype = 6'h00,
    OpJ     = 6'h02,
    OpJal   = 6'h03,
    OpBeq   = 6'h04,
    OpBne   = 6'h05,
    OpAddi  = 6'h08,
    OpAddiu = 6'h09,
    OpSlti  = 6'h0a,
    OpSltiu = 6'h0b,
    OpAndi  = 6'h0c,
    OpOri   = 6'h0d,
    OpXori  = 6'h0e,
    OpLui   = 6'h0f,
    OpLw    = 6'h23,
    OpSw    = 6'h2b,
    OpHalt  = 6'h3f
  } opcode_t;

  typedef enum logic [5:0] {
    FnSll  = 6'h00,
    FnSrl  = 6'h02,
    FnJr   = 6'h08,
    FnAdd  = 6'h20,
    FnAddu = 6'h21,
    FnSub  = 6'h22,
    FnSubu = 6'h23,
    FnAnd  = 6'h24,
    FnOr   = 6'h25,
    FnXor  = 6'h26,
    FnNor  = 6'h27,
    FnSlt  = 6'h2a,
    FnSltu = 6'h2b
  } funct_t;

  typedef enum logic [3:0] {
    AluSll, AluSrl, AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt, AluSltu
  } aluop_t;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalted} ctrl_state_t;
  typedef enum logic [1:0] {PcPc4, PcBranch, PcJump, PcJr} pcsrc_t;
  typedef enum logic [1:0] {WsRd, WsRt, WsR31} wsel_t;
  typedef enum logic [1:0] {WdAlu, WdMem, WdPc, WdLui} wdat_t;
  typedef enum logic [1:0] {AsReg, AsSext, AsZext, AsShamt} alusrc_t;

  // Opcodes that need the EXEC stage; anything unlisted retires as a no-op.
  function automatic logic needs_exec(opcode_t op);
    unique case (op)
      OpRtype, OpBeq, OpBne, OpAddi, OpAddiu, OpSlti, OpSltiu,
      OpAndi, OpOri, OpXori, OpLui, OpLw, OpSw: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// Combinational ALU decode: opcode/funct to ALU operation and B-operand source.
module alu_ctrl
  import cpu_types_pkg::*;
(
  input  opcode_t opcode,
  input  funct_t  funct,
  output aluop_t  aluop,
  output alusrc_t alusrc
);

  always_comb begin
    aluop  = AluAdd;
    alusrc = AsReg;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnSll:         begin aluop = AluSll; alusrc = AsShamt; end
          FnSrl:         begin aluop = AluSrl; alusrc = AsShamt; end
          FnAdd, FnAddu: aluop = AluAdd;
          FnSub, FnSubu: aluop = AluSub;
          FnAnd:         aluop = AluAnd;
          FnOr:          aluop = AluOr;
          FnXor:         aluop = AluXor;
          FnNor:         aluop = AluNor;
          FnSlt:         aluop = AluSlt;
          FnSltu:        aluop = AluSltu;
          default:       aluop = AluAdd;
        endcase
      end
      OpAddi, OpAddiu: begin aluop = AluAdd;  alusrc = AsSext; end
      OpSlti:          begin aluop = AluSlt;  alusrc = AsSext; end
      OpSltiu:         begin aluop = AluSltu; alusrc = AsSext; end
      OpAndi:          begin aluop = AluAnd;  alusrc = AsZext; end
      OpOri:           begin aluop = AluOr;   alusrc = AsZext; end
      OpXori:          begin aluop = AluXor;  alusrc = AsZext; end
      OpBeq, OpBne:    begin aluop = AluSub;  alusrc = AsReg;  end
      OpLw, OpSw:      begin aluop = AluAdd;  alusrc = AsSext; end
      default:         begin aluop = AluAdd;  alusrc = AsReg;  end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory requests and
// datapath enables/selects. Outputs decode combinationally from state and inputs.
module multicycle_ctrl
  import cpu_types_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic    CLK,
  input  logic    RST,
  input  opcode_t opcode,
  input  funct_t  funct,
  input  logic    zero,
  input  logic    ihit,
  input  logic    dhit,
  output logic    iREN,
  output logic    dREN,
  output logic    dWEN,
  output logic    ir_en,
  output logic    pc_en,
  output pcsrc_t  pcsrc,
  output logic    regwr,
  output wsel_t   wsel,
  output wdat_t   wdat_sel,
  output alusrc_t alusrc,
  output aluop_t  aluop,
  output logic    halt
);

  ctrl_state_t state_q, state_d;
  aluop_t      dec_aluop;
  alusrc_t     dec_alusrc;

  alu_ctrl u_alu_ctrl (
    .opcode (opcode),
    .funct  (funct),
    .aluop  (dec_aluop),
    .alusrc (dec_alusrc)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (ihit) state_d = StDecode;
      StDecode: begin
        if (opcode == OpHalt)     state_d = StHalted;
        else if (needs_exec(opcode)) state_d = StExec;
        else                      state_d = StFetch;
      end
      StExec: begin
        case (opcode)
          OpRtype:      state_d = (funct == FnJr) ? StFetch : StWb;
          OpBeq, OpBne: state_d = StFetch;
          OpLw, OpSw:   state_d = StMem;
          default:      state_d = StWb;
        endcase
      end
      StMem:    if (dhit) state_d = (opcode == OpLw) ? StWb : StFetch;
      StWb:     state_d = StFetch;
      StHalted: state_d = HALT_STICKY ? StHalted : StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Everything defaults to idle so reset and the idle states need no explicit assignments.
  always_comb begin
    iREN     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pcsrc    = PcPc4;
    regwr    = 1'b0;
    wsel     = WsRd;
    wdat_sel = WdAlu;
    alusrc   = AsReg;
    aluop    = AluSll;
    halt     = 1'b0;
    if (!RST) begin
      unique case (state_q)
        StFetch: begin
          iREN  = 1'b1;
          ir_en = ihit;
          pc_en = ihit;
        end
        StDecode: begin
          if (opcode == OpJ || opcode == OpJal) begin
            pc_en = 1'b1;
            pcsrc = PcJump;
          end
          if (opcode == OpJal) begin
            regwr    = 1'b1;
            wsel     = WsR31;
            wdat_sel = WdPc;
          end
        end
        StExec: begin
          aluop  = dec_aluop;
          alusrc = dec_alusrc;
          if (opcode == OpRtype && funct == FnJr) begin
            pc_en = 1'b1;
            pcsrc = PcJr;
          end else if ((opcode == OpBeq && zero) || (opcode == OpBne && !zero)) begin
            pc_en = 1'b1;
            pcsrc = PcBranch;
          end
        end
        StMem: begin
          aluop  = dec_aluop;
          alusrc = dec_alusrc;
          dREN   = (opcode == OpLw);
          dWEN   = (opcode == OpSw);
        end
        StWb: begin
          aluop    = dec_aluop;
          alusrc   = dec_alusrc;
          regwr    = 1'b1;
          wsel     = (opcode == OpRtype) ? WsRd : WsRt;
          wdat_sel = (opcode == OpLui) ? WdLui : (opcode == OpLw) ? WdMem : WdAlu;
        end
        StHalted: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
